// File: rtl/irst_fetch_ctrl_pkg.sv
// Purpose: shared IRST state encodings, LFSR constants and trigger decode for the fetch controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package irst_fetch_ctrl_pkg;

    localparam int DEF_PC_WIDTH = 8;

    // Galois feedback mask for the 16-bit self-test LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_MISSION = 2'd2,
        ST_DONE    = 2'd3
    } irst_state_t;

    // MISSION exit decision: more LFSR bits ANDed together means a rarer exit.
    function automatic logic prob_trigger(input logic [1:0] prob, input logic [2:0] rnd);
        logic hit;
        case (prob)
            2'b00:   hit = 1'b1;
            2'b01:   hit = rnd[0];
            2'b10:   hit = rnd[0] & rnd[1];
            default: hit = &rnd;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/irst_fetch_ctrl_if.sv
// Purpose: bundles configuration, fetch controls and IMEM-side outputs of the fetch controller.
// Latency: n/a (wires only).
// Backpressure: none; fetch_en is the only throttle, sampled every clock.
// Ports: master drives cfg_*/fetch controls and observes pc/write_en/status; slave is the controller.
interface irst_fetch_ctrl_if #(
    parameter int PC_WIDTH  = 8,
    parameter int OFF_WIDTH = 6,
    parameter int CNT_WIDTH = 6
);
    logic                 cfg_start;
    logic [PC_WIDTH-2:0]  cfg_limit;
    logic [CNT_WIDTH-1:0] cfg_rounds;
    logic [1:0]           cfg_prob;
    logic                 instruction_fetch_en;
    logic                 branch_taken;
    logic [OFF_WIDTH-1:0] branch_offset_imm;
    logic [PC_WIDTH-1:0]  pc;
    logic                 write_en;
    logic                 irst_busy;
    logic                 irst_done;
    logic [CNT_WIDTH-1:0] round_cnt;

    modport master (
        output cfg_start, cfg_limit, cfg_rounds, cfg_prob,
        output instruction_fetch_en, branch_taken, branch_offset_imm,
        input  pc, write_en, irst_busy, irst_done, round_cnt
    );

    modport slave (
        input  cfg_start, cfg_limit, cfg_rounds, cfg_prob,
        input  instruction_fetch_en, branch_taken, branch_offset_imm,
        output pc, write_en, irst_busy, irst_done, round_cnt
    );
endinterface

// File: rtl/irst_fetch_ctrl_lfsr.sv
// Purpose: 16-bit Galois LFSR supplying pseudo-random bits for MISSION exit decisions.
// Latency: state updates one clock after shift_en/load; load wins over shift.
// Backpressure: none; holds its value whenever shift_en and load are both low.
// Ports: clk, rst_n (async, active low), shift_en, load (reload SEED), state (current value).
module irst_fetch_ctrl_lfsr
    import irst_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en,
    input  logic        load,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (shift_en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/irst_fetch_ctrl.sv
// Purpose: IF-stage PC generator with an in-run self-test sequencer that sweeps IMEM in FETCH/MISSION passes.
// Latency: pc/write_en/status are combinational on registered state; inputs take effect at the next edge.
// Backpressure: instruction_fetch_en low freezes pc_reg; cfg_start low aborts a test run at the next edge.
// Ports: clk, rst_n (async, active low), bus (slave side of irst_fetch_ctrl_if).
module irst_fetch_ctrl
    import irst_fetch_ctrl_pkg::*;
#(
    parameter int          PC_WIDTH  = DEF_PC_WIDTH,
    parameter int          OFF_WIDTH = 6,
    parameter int          CNT_WIDTH = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    irst_fetch_ctrl_if.slave   bus
);

    irst_state_t          state;
    logic [PC_WIDTH-1:0]  pc_reg;
    logic [PC_WIDTH-1:0]  next_pc;
    logic [PC_WIDTH-1:0]  offset_ext;
    logic [CNT_WIDTH-1:0] round_cnt;
    logic [CNT_WIDTH-1:0] round_inc;
    logic [15:0]          lfsr;
    logic                 busy_st;
    logic                 toggle;
    logic                 trigger;
    logic                 lfsr_load;
    logic                 lfsr_unused;

    assign busy_st = (state == ST_FETCH) || (state == ST_MISSION);

    // Sign-extending cast keeps the offset two's complement at any PC width.
    assign offset_ext = PC_WIDTH'($signed(bus.branch_offset_imm));

    always_comb begin
        next_pc = pc_reg;
        if (bus.instruction_fetch_en) begin
            if (bus.branch_taken) begin
                next_pc = pc_reg + offset_ext;
            end else begin
                next_pc = pc_reg + PC_WIDTH'(1);
            end
        end
    end

    // A sweep ends when the address about to be fetched leaves the configured low window.
    assign toggle  = busy_st && (next_pc > {1'b0, bus.cfg_limit});
    assign trigger = prob_trigger(bus.cfg_prob, lfsr[2:0]);

    // Saturating increment; the FSM compare can never pass at all-ones anyway.
    assign round_inc = (round_cnt == '1) ? round_cnt : round_cnt + CNT_WIDTH'(1);

    assign lfsr_load   = (state == ST_IDLE) && bus.cfg_start;
    assign lfsr_unused = ^lfsr[15:3];

    irst_fetch_ctrl_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (busy_st),
        .load     (lfsr_load),
        .state    (lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc_reg    <= '0;
            round_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pc_reg <= next_pc;
                    if (bus.cfg_start) begin
                        state     <= ST_FETCH;
                        round_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (!bus.cfg_start) begin
                        state  <= ST_IDLE;
                        pc_reg <= '0;
                    end else if (toggle) begin
                        pc_reg <= '0;
                        if (round_cnt < bus.cfg_rounds) begin
                            state     <= ST_MISSION;
                            round_cnt <= round_inc;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        pc_reg <= next_pc;
                    end
                end
                ST_MISSION: begin
                    if (!bus.cfg_start) begin
                        state  <= ST_IDLE;
                        pc_reg <= '0;
                    end else if (toggle) begin
                        // Without a trigger the mission sweep simply restarts from 0.
                        pc_reg <= '0;
                        if (trigger) begin
                            state <= ST_FETCH;
                        end
                    end else begin
                        pc_reg <= next_pc;
                    end
                end
                ST_DONE: begin
                    pc_reg <= next_pc;
                    if (!bus.cfg_start) begin
                        state     <= ST_IDLE;
                        round_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // During a run the MSB selects the mission half; the low bits come straight from pc_reg.
    assign bus.pc        = busy_st ? {(state == ST_MISSION), pc_reg[PC_WIDTH-2:0]} : pc_reg;
    assign bus.write_en  = (state == ST_MISSION);
    assign bus.irst_busy = busy_st;
    assign bus.irst_done = (state == ST_DONE);
    assign bus.round_cnt = round_cnt;

endmodule

// File: tb/tb_irst_fetch_ctrl.sv
module tb_irst_fetch_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic rst_n;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int prob_total;

    irst_fetch_ctrl_if #(.PC_WIDTH(8), .OFF_WIDTH(6), .CNT_WIDTH(6)) bus ();

    irst_fetch_ctrl #(
        .PC_WIDTH  (8),
        .OFF_WIDTH (6),
        .CNT_WIDTH (6),
        .LFSR_SEED (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1);
    end

    // Expected pc / write_en after each edge of the one-round run (limit=3, rounds=1, prob=00).
    logic [7:0] r1_pc [12] = '{8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83,
                               8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    logic       r1_we [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n                    = 1'b0;
        bus.cfg_start            = 1'b0;
        bus.cfg_limit            = '0;
        bus.cfg_rounds           = '0;
        bus.cfg_prob             = 2'b00;
        bus.instruction_fetch_en = 1'b0;
        bus.branch_taken         = 1'b0;
        bus.branch_offset_imm    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Expected MISSION sweep total for limit=1, prob=11: each sweep is two cycles, exit tested on the second.
    function automatic int model_sweeps(input int rounds);
        logic [15:0] l;
        int          sw;
        logic        trig;
        l  = SEED;
        sw = 0;
        for (int r = 0; r < rounds; r++) begin
            l = lfsr_adv(lfsr_adv(l));
            trig = 1'b0;
            while (!trig) begin
                l    = lfsr_adv(l);
                trig = &l[2:0];
                l    = lfsr_adv(l);
                sw++;
            end
        end
        return sw;
    endfunction

    task automatic run_prob(output int m1, output int total);
        int  mission_idx;
        logic prev_we;
        m1          = 0;
        total       = 0;
        mission_idx = 0;
        prev_we     = 1'b0;
        bus.cfg_limit            = 7'd1;
        bus.cfg_rounds           = 6'd4;
        bus.cfg_prob             = 2'b11;
        bus.instruction_fetch_en = 1'b0;
        bus.cfg_start            = 1'b1;
        step();
        bus.instruction_fetch_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (bus.write_en && !prev_we) mission_idx++;
            prev_we = bus.write_en;
            if (bus.write_en && bus.pc == 8'h81) begin
                total++;
                if (mission_idx == 1) m1++;
            end
            if (bus.irst_done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.pc, bus.write_en, bus.irst_busy, bus.irst_done, bus.round_cnt} !== 17'd0)
            $display("FAIL reset_outputs: got pc=%h we=%b busy=%b done=%b rc=%0d, wanted all zero",
                     bus.pc, bus.write_en, bus.irst_busy, bus.irst_done, bus.round_cnt);
        else pass_cnt++;
    endtask

    task automatic test_function();
        do_reset();
        bus.instruction_fetch_en = 1'b1;
        chk_cnt++;
        if (bus.pc !== 8'h00) $display("FAIL func_pc0: got %h, wanted 00", bus.pc);
        else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_cnt++;
            if (bus.pc !== 8'(i) || bus.write_en !== 1'b0)
                $display("FAIL func_inc%0d: got pc=%h we=%b, wanted pc=%h we=0", i, bus.pc, bus.write_en, 8'(i));
            else pass_cnt++;
        end
        bus.branch_taken      = 1'b1;
        bus.branch_offset_imm = 6'b111110;
        step();
        chk_cnt++;
        if (bus.pc !== 8'h03) $display("FAIL func_branch_neg2: got %h, wanted 03", bus.pc);
        else pass_cnt++;
        bus.branch_taken         = 1'b0;
        bus.instruction_fetch_en = 1'b0;
        step();
        chk_cnt++;
        if (bus.pc !== 8'h03) $display("FAIL func_hold: got %h, wanted 03", bus.pc);
        else pass_cnt++;
    endtask

    task automatic test_one_round();
        do_reset();
        bus.cfg_limit  = 7'd3;
        bus.cfg_rounds = 6'd1;
        bus.cfg_prob   = 2'b00;
        bus.cfg_start  = 1'b1;
        step();
        chk_cnt++;
        if (bus.irst_busy !== 1'b1 || bus.pc !== 8'h00)
            $display("FAIL round_enter: got busy=%b pc=%h, wanted busy=1 pc=00", bus.irst_busy, bus.pc);
        else pass_cnt++;
        bus.instruction_fetch_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_cnt++;
            if (bus.pc !== r1_pc[i] || bus.write_en !== r1_we[i])
                $display("FAIL round_step%0d: got pc=%h we=%b, wanted pc=%h we=%b",
                         i, bus.pc, bus.write_en, r1_pc[i], r1_we[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (bus.irst_done !== 1'b1 || bus.irst_busy !== 1'b0 || bus.round_cnt !== 6'd1)
            $display("FAIL round_done: got done=%b busy=%b rc=%0d, wanted done=1 busy=0 rc=1",
                     bus.irst_done, bus.irst_busy, bus.round_cnt);
        else pass_cnt++;
        bus.cfg_start = 1'b0;
        step();
        chk_cnt++;
        if (bus.irst_done !== 1'b0 || bus.round_cnt !== 6'd0)
            $display("FAIL round_to_idle: got done=%b rc=%0d, wanted done=0 rc=0", bus.irst_done, bus.round_cnt);
        else pass_cnt++;
    endtask

    task automatic test_zero_rounds();
        logic       we_seen;
        logic [7:0] exp_pc [3] = '{8'h01, 8'h02, 8'h00};
        do_reset();
        we_seen        = 1'b0;
        bus.cfg_limit  = 7'd2;
        bus.cfg_rounds = 6'd0;
        bus.cfg_start  = 1'b1;
        step();
        we_seen |= bus.write_en;
        chk_cnt++;
        if (bus.pc !== 8'h00 || bus.irst_busy !== 1'b1)
            $display("FAIL zero_enter: got pc=%h busy=%b, wanted pc=00 busy=1", bus.pc, bus.irst_busy);
        else pass_cnt++;
        bus.instruction_fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            we_seen |= bus.write_en;
            chk_cnt++;
            if (bus.pc !== exp_pc[i])
                $display("FAIL zero_step%0d: got pc=%h, wanted %h", i, bus.pc, exp_pc[i]);
            else pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (bus.irst_done !== 1'b1) $display("FAIL zero_done_hold%0d: got %b, wanted 1", i, bus.irst_done);
            else pass_cnt++;
            step();
            we_seen |= bus.write_en;
        end
        bus.cfg_start = 1'b0;
        step();
        chk_cnt++;
        if (bus.irst_done !== 1'b0 || bus.irst_busy !== 1'b0)
            $display("FAIL zero_release: got done=%b busy=%b, wanted 0 0", bus.irst_done, bus.irst_busy);
        else pass_cnt++;
        chk_cnt++;
        if (we_seen !== 1'b0) $display("FAIL zero_no_write: got write_en seen=%b, wanted 0", we_seen);
        else pass_cnt++;
    endtask

    task automatic test_prob();
        int m1;
        int total;
        do_reset();
        run_prob(m1, total);
        prob_total = total;
        chk_cnt++;
        if (bus.irst_done !== 1'b1 || bus.round_cnt !== 6'd4)
            $display("FAIL prob_done: got done=%b rc=%0d, wanted done=1 rc=4", bus.irst_done, bus.round_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (m1 !== 2) $display("FAIL prob_first_mission: got %0d sweeps, wanted 2", m1);
        else pass_cnt++;
        chk_cnt++;
        if (total !== model_sweeps(4))
            $display("FAIL prob_total_sweeps: got %0d, wanted %0d", total, model_sweeps(4));
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic found;
        do_reset();
        found          = 1'b0;
        bus.cfg_limit  = 7'd3;
        bus.cfg_rounds = 6'd1;
        bus.cfg_start  = 1'b1;
        step();
        bus.instruction_fetch_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.pc == 8'h82) begin
                found = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (found !== 1'b1) $display("FAIL abort_reach_82: got found=%b, wanted 1", found);
        else pass_cnt++;
        bus.cfg_start = 1'b0;
        step();
        chk_cnt++;
        if (bus.pc !== 8'h00 || bus.write_en !== 1'b0 || bus.irst_busy !== 1'b0 || bus.irst_done !== 1'b0)
            $display("FAIL abort_idle: got pc=%h we=%b busy=%b done=%b, wanted 00 0 0 0",
                     bus.pc, bus.write_en, bus.irst_busy, bus.irst_done);
        else pass_cnt++;
        chk_cnt++;
        if (bus.round_cnt !== 6'd1) $display("FAIL abort_rc_hold: got %0d, wanted 1", bus.round_cnt);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic found;
        int   m1;
        int   total;
        do_reset();
        found          = 1'b0;
        bus.cfg_limit  = 7'd3;
        bus.cfg_rounds = 6'd1;
        bus.cfg_start  = 1'b1;
        step();
        bus.instruction_fetch_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.irst_busy && !bus.write_en && bus.round_cnt == 6'd1 && bus.pc == 8'h02) begin
                found = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (found !== 1'b1) $display("FAIL arst_reach_fetch: got found=%b, wanted 1", found);
        else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.pc, bus.write_en, bus.irst_busy, bus.irst_done, bus.round_cnt} !== 17'd0)
            $display("FAIL arst_immediate: got pc=%h we=%b busy=%b done=%b rc=%0d, wanted all zero",
                     bus.pc, bus.write_en, bus.irst_busy, bus.irst_done, bus.round_cnt);
        else pass_cnt++;
        bus.cfg_start            = 1'b0;
        bus.instruction_fetch_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_prob(m1, total);
        chk_cnt++;
        if (m1 !== 2) $display("FAIL arst_lfsr_first: got %0d sweeps, wanted 2", m1);
        else pass_cnt++;
        chk_cnt++;
        if (total !== prob_total) $display("FAIL arst_lfsr_repeat: got %0d sweeps, wanted %0d", total, prob_total);
        else pass_cnt++;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_function();
        test_one_round();
        test_zero_rounds();
        test_prob();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
